// File: rtl/s2a_sample_packer.sv
// rtl/s2a_sample_packer.sv - decimate and pack 12-bit I/Q samples into buffer write words
//
// Sclk     : stream clock, all state on its rising edge
// rst      : synchronous active-high reset
// sync     : system sync, restarts packing at a word boundary
// en       : capture enable, sampled only between words
// mode     : 0 = one 16-bit I/Q sample per word, 1 = two 8-bit I/Q samples per word
// tp       : 1 = substitute the counting test pattern for the RF samples
// decim    : keep one of every decim+1 accepted samples
// rx_valid : RF sample strobe
// rx_i     : I sample, two's complement
// rx_q     : Q sample, two's complement
// Ien      : one-cycle buffer write strobe per completed word
// Idata    : buffer write data, valid with Ien
// scnt     : words written since reset/sync, wraps at 2^32

module s2a_sample_packer #(
    parameter int DW = 32,
    parameter int SW = 12
) (
    input  logic          Sclk,
    input  logic          rst,
    input  logic          sync,
    input  logic          en,
    input  logic          mode,
    input  logic          tp,
    input  logic [7:0]    decim,
    input  logic          rx_valid,
    input  logic [SW-1:0] rx_i,
    input  logic [SW-1:0] rx_q,
    output logic          Ien,
    output logic [DW-1:0] Idata,
    output logic [31:0]   scnt
);

    localparam int HW = DW / 2;   // half-word: one I or Q in mode 0, one packed sample in mode 1
    localparam int BW = HW / 2;   // bits kept per component in mode 1

    typedef enum logic {
        PH_LO = 1'b0,   // next kept sample starts a word
        PH_HI = 1'b1    // low half held, next kept sample completes the word
    } phase_t;

    phase_t          phase;
    phase_t          phase_nx;
    logic            run;
    logic            mode_l;
    logic [7:0]      dcnt;
    logic [SW-1:0]   tpcnt;
    logic [HW-1:0]   low;

    logic            accept;
    logic            keep;
    logic [SW-1:0]   src_i;
    logic [SW-1:0]   src_q;
    logic [HW-1:0]   half;
    logic [DW-1:0]   wide;
    logic [DW-1:0]   word;
    logic            word_done;

    always_comb begin
        accept    = run & (tp | rx_valid);
        keep      = accept & (dcnt == 8'd0);
        src_i     = tp ? tpcnt  : rx_i;
        src_q     = tp ? ~tpcnt : rx_q;
        half      = {src_q[SW-1 -: BW], src_i[SW-1 -: BW]};
        wide      = {{(HW-SW){src_q[SW-1]}}, src_q, {(HW-SW){src_i[SW-1]}}, src_i};
        phase_nx  = phase;
        word_done = 1'b0;
        word      = wide;
        if (keep) begin
            if (!mode_l) begin
                word_done = 1'b1;
            end else if (phase == PH_LO) begin
                phase_nx = PH_HI;
            end else begin
                phase_nx  = PH_LO;
                word_done = 1'b1;
                word      = {half, low};
            end
        end
    end

    always_ff @(posedge Sclk) begin
        if (rst) begin
            phase  <= PH_LO;
            run    <= 1'b0;
            mode_l <= 1'b0;
            dcnt   <= 8'd0;
            tpcnt  <= '0;
            low    <= '0;
            Ien    <= 1'b0;
            Idata  <= '0;
            scnt   <= 32'd0;
        end else if (sync) begin
            // Idata deliberately keeps its last value across sync.
            phase  <= PH_LO;
            run    <= 1'b0;
            mode_l <= 1'b0;
            dcnt   <= 8'd0;
            tpcnt  <= '0;
            low    <= '0;
            Ien    <= 1'b0;
            scnt   <= 32'd0;
        end else begin
            phase <= phase_nx;

            // Enable and format are only re-sampled between words, so a
            // word is never cut short or built from mixed formats.
            if (phase == PH_LO) begin
                run    <= en;
                mode_l <= mode;
            end

            // A run rising edge restarts decimation so its first sample is kept.
            if (phase == PH_LO && en && !run) begin
                dcnt <= 8'd0;
            end else if (accept) begin
                dcnt <= (dcnt == 8'd0) ? decim : dcnt - 8'd1;
            end

            if (keep && tp) begin
                tpcnt <= tpcnt + SW'(1);
            end

            if (keep && mode_l && phase == PH_LO) begin
                low <= half;
            end

            Ien <= word_done;
            if (word_done) begin
                Idata <= word;
                scnt  <= scnt + 32'd1;
            end
        end
    end

endmodule
